// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Owner encoding tags which port the in-flight response belongs to.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned ADDR_WORDS_DEF   = 1536;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 4;
  localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

  // Word index beyond the implemented memory; byte-lane bits play no part.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned words);
    return ({2'b00, addr[31:2]} >= words);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data ports, plus a range
// check of whichever address wins.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WORDS   = ADDR_WORDS_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    i_req,
  input  logic                    d_req,
  input  logic [STARVE_CNT_W-1:0] wait_cnt,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             d_addr,
  output owner_e                  sel,
  output logic                    oor
);

  logic starved;

  assign starved = (wait_cnt >= STARVE_CNT_W'(STARVE_LIMIT));

  always_comb begin
    sel = OWN_NONE;
    if (i_req && d_req) begin
      sel = starved ? OWN_I : OWN_D;
    end else if (i_req) begin
      sel = OWN_I;
    end else if (d_req) begin
      sel = OWN_D;
    end
  end

  always_comb begin
    oor = 1'b0;
    case (sel)
      OWN_I:   oor = addr_oor(i_addr, ADDR_WORDS);
      OWN_D:   oor = addr_oor(d_addr, ADDR_WORDS);
      default: oor = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port word memory shared between CPU fetch and data ports: one grant
// per cycle, data priority with a starvation override, one-cycle responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WORDS   = ADDR_WORDS_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_rstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  logic [STARVE_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_e                  resp_owner_q, resp_owner_d;
  logic                    resp_err_q, resp_err_d;
  logic                    resp_rd_q, resp_rd_d;

  owner_e sel;
  logic   oor;
  logic   d_is_write;
  logic   resp_data_ok;

  assign d_is_write = (d_wmask != 4'b0000);

  mem_arb_pick #(
    .ADDR_WORDS   (ADDR_WORDS),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .wait_cnt (wait_cnt_q),
    .i_addr   (i_addr),
    .d_addr   (d_addr),
    .sel      (sel),
    .oor      (oor)
  );

  assign i_gnt = (sel == OWN_I);
  assign d_gnt = (sel == OWN_D);

  // Out-of-range grants are acknowledged but leave the memory port idle.
  always_comb begin
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!oor) begin
      case (sel)
        OWN_I: begin
          mem_addr  = i_addr;
          mem_rstrb = 1'b1;
        end
        OWN_D: begin
          mem_addr = d_addr;
          if (d_is_write) begin
            mem_wmask = d_wmask;
            mem_wdata = d_wdata;
          end else begin
            mem_rstrb = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (i_req && !i_gnt) begin
      wait_cnt_d = (wait_cnt_q == STARVE_CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    resp_owner_d = sel;
    resp_err_d   = oor;
    resp_rd_d    = i_gnt || (d_gnt && !d_is_write);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q   <= '0;
      resp_owner_q <= OWN_NONE;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  // Read data is only forwarded for in-range reads; acks and errors return zero.
  assign resp_data_ok = resp_rd_q && !resp_err_q;

  assign i_rvalid = (resp_owner_q == OWN_I);
  assign d_rvalid = (resp_owner_q == OWN_D);
  assign i_err    = i_rvalid && resp_err_q;
  assign d_err    = d_rvalid && resp_err_q;
  assign i_rdata  = (i_rvalid && resp_data_ok) ? mem_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && resp_data_ok) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a 1-cycle registered-read memory model: directed
// vector table, hand-written multi-cycle sequences and randomized traffic.
module tb_mem_arbiter;

  localparam int unsigned WORDS  = 1536;
  localparam int unsigned SLIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_rstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.ADDR_WORDS(WORDS), .STARVE_LIMIT(SLIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rstrb(mem_rstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: byte-masked write, registered read, contents survive reset.
  logic [31:0] mem [0:WORDS-1];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= 32'h0;
    end else begin
      if (mem_wmask != 4'b0 && mem_addr[31:2] < 30'(WORDS)) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem_rstrb && mem_addr[31:2] < 30'(WORDS)) mem_rdata <= mem[mem_addr[12:2]];
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, act, exp);
  endfunction

  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic [31:0] daddr; logic [31:0] dwdata; logic [3:0] dwmask;
    logic e_ignt, e_dgnt, e_rstrb; logic [3:0] e_wmask; logic [31:0] e_maddr;
    logic e_irv, e_drv, e_ierr, e_derr; logic [31:0] e_irdata, e_drdata;
  } vec_t;

  function automatic vec_t mk(int ireq, logic [31:0] iaddr, int dreq, logic [31:0] daddr,
                              logic [31:0] dwdata, logic [3:0] dwmask,
                              int ignt, int dgnt, int rstrb, logic [3:0] wmask, logic [31:0] maddr,
                              int irv, int drv, int ierr, int derr,
                              logic [31:0] irdata, logic [31:0] drdata);
    vec_t v;
    v.ireq = (ireq != 0); v.iaddr = iaddr;
    v.dreq = (dreq != 0); v.daddr = daddr; v.dwdata = dwdata; v.dwmask = dwmask;
    v.e_ignt = (ignt != 0); v.e_dgnt = (dgnt != 0); v.e_rstrb = (rstrb != 0);
    v.e_wmask = wmask; v.e_maddr = maddr;
    v.e_irv = (irv != 0); v.e_drv = (drv != 0); v.e_ierr = (ierr != 0); v.e_derr = (derr != 0);
    v.e_irdata = irdata; v.e_drdata = drdata;
    return v;
  endfunction

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
  endtask

  // Behavioural reference for randomized traffic.
  int          denied_run;
  int          p_owner;          // 0 none, 1 fetch, 2 data
  logic        p_err;
  logic [31:0] p_data;
  logic [31:0] shadow [0:63];    // words at byte 0x1000..0x10FC
  logic        pend_i, pend_d;
  logic [31:0] pi_addr, pd_addr, pd_wdata;
  logic [3:0]  pd_mask;

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h1800 + 32'(4 * $urandom_range(0, 255));
    if (r == 1) return 32'hFFFF_FFFC;
    return 32'h1000 + 32'(4 * $urandom_range(0, 63));
  endfunction

  task automatic rnd_cycle(int n);
    int          win;
    logic [31:0] a;
    logic        out_of_range, is_rd;
    int          idx;
    @(negedge clk);
    if (!pend_i && $urandom_range(0, 9) < 6) begin
      pend_i = 1'b1; pi_addr = rnd_addr();
    end
    if (!pend_d && $urandom_range(0, 9) < 7) begin
      pend_d = 1'b1; pd_addr = rnd_addr(); pd_wdata = $urandom;
      pd_mask = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    end
    i_req = pend_i; i_addr = pend_i ? pi_addr : 32'h0;
    d_req = pend_d; d_addr = pend_d ? pd_addr : 32'h0;
    d_wdata = pend_d ? pd_wdata : 32'h0; d_wmask = pend_d ? pd_mask : 4'h0;
    #1;
    chk("rnd_i_rvalid", i_rvalid, (p_owner == 1));
    chk("rnd_d_rvalid", d_rvalid, (p_owner == 2));
    chk("rnd_i_err", i_err, (p_owner == 1) && p_err);
    chk("rnd_d_err", d_err, (p_owner == 2) && p_err);
    chk("rnd_i_rdata", i_rdata, (p_owner == 1) ? p_data : 32'h0);
    chk("rnd_d_rdata", d_rdata, (p_owner == 2) ? p_data : 32'h0);
    // Data first, unless fetch has already been refused SLIMIT times in a row.
    if (pend_d && (!pend_i || denied_run < SLIMIT)) win = 2;
    else if (pend_i) win = 1;
    else win = 0;
    chk("rnd_i_gnt", i_gnt, (win == 1));
    chk("rnd_d_gnt", d_gnt, (win == 2));
    a = (win == 1) ? pi_addr : pd_addr;
    out_of_range = (win != 0) && (a >= 32'(WORDS * 4));
    is_rd = (win == 1) || (win == 2 && pd_mask == 4'h0);
    chk("rnd_mem_rstrb", mem_rstrb, (win != 0) && !out_of_range && is_rd);
    chk("rnd_mem_wmask", mem_wmask, (win == 2 && !out_of_range) ? pd_mask : 4'h0);
    if (win != 0 && !out_of_range) chk("rnd_mem_addr", mem_addr, a);
    if (win == 0) chk("rnd_mem_addr_idle", mem_addr, 32'h0);
    if (win != 0)
      $display("rnd %0d gnt=%s addr=%h mask=%h oor=%0d", n, (win == 1) ? "I" : "D", a,
               (win == 2) ? pd_mask : 4'h0, out_of_range);
    p_owner = win; p_err = out_of_range; p_data = 32'h0;
    idx = int'((a - 32'h1000) >> 2);
    if (win != 0 && !out_of_range && is_rd) p_data = shadow[idx];
    if (win == 2 && !out_of_range && !is_rd)
      for (int b = 0; b < 4; b++)
        if (pd_mask[b]) shadow[idx][8*b +: 8] = pd_wdata[8*b +: 8];
    if (pend_i && win != 1) denied_run = (denied_run >= 15) ? 15 : denied_run + 1;
    else denied_run = 0;
    if (win == 1) pend_i = 1'b0;
    if (win == 2) pend_d = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  vec_t tbl [14];

  initial begin
    tbl[0]  = mk(0, 0, 1, 32'h0, 32'hA5A5_0001, 4'hF,  0,1,0,4'hF,32'h0,    0,0,0,0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 32'h4, 32'h5A5A_0002, 4'hF,  0,1,0,4'hF,32'h4,    0,1,0,0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0,1,0,4'hF,32'h100, 0,1,0,0, 0, 0);
    tbl[3]  = mk(1, 32'h100, 0, 0, 0, 4'h0,            1,0,1,4'h0,32'h100,  0,1,0,0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 32'h200, 32'h1122_3344, 4'hF, 0,1,0,4'hF,32'h200, 1,0,0,0, 32'hDEAD_BEEF, 0);
    tbl[5]  = mk(0, 0, 1, 32'h200, 32'h0000_AB00, 4'h2, 0,1,0,4'h2,32'h200, 0,1,0,0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 32'h200, 0, 4'h0,             0,1,1,4'h0,32'h200, 0,1,0,0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 32'h1800, 0, 4'h0,            0,1,0,4'h0,32'h0,   0,1,0,0, 0, 32'h1122_AB44);
    tbl[8]  = mk(0, 0, 0, 0, 0, 4'h0,                   0,0,0,4'h0,32'h0,   0,1,0,1, 0, 0);
    tbl[9]  = mk(1, 32'h17FC, 0, 0, 0, 4'h0,            1,0,1,4'h0,32'h17FC,0,0,0,0, 0, 0);
    tbl[10] = mk(1, 32'h2000_0000, 0, 0, 0, 4'h0,       1,0,0,4'h0,32'h0,   1,0,0,0, 0, 0);
    tbl[11] = mk(0, 0, 1, 32'h1FFC, 32'hFFFF_FFFF, 4'hF,0,1,0,4'h0,32'h0,   1,0,1,0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 4'h0,                   0,0,0,4'h0,32'h0,   0,1,0,1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 4'h0,                   0,0,0,4'h0,32'h0,   0,0,0,0, 0, 0);

    idle_inputs();
    resetn  = 1'b0;
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_i_err", i_err, 1'b0);
    chk("rst_d_err", d_err, 1'b0);
    chk("rst_gnt", {i_gnt, d_gnt}, 2'b00);
    mem_clr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Vector table: one row per cycle; response fields refer to the previous row.
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      i_req = tbl[r].ireq; i_addr = tbl[r].iaddr;
      d_req = tbl[r].dreq; d_addr = tbl[r].daddr;
      d_wdata = tbl[r].dwdata; d_wmask = tbl[r].dwmask;
      #1;
      $display("vec %0d i_gnt=%0d d_gnt=%0d rstrb=%0d wmask=%h i_rv=%0d d_rv=%0d",
               r, i_gnt, d_gnt, mem_rstrb, mem_wmask, i_rvalid, d_rvalid);
      chk($sformatf("v%0d_i_gnt", r), i_gnt, tbl[r].e_ignt);
      chk($sformatf("v%0d_d_gnt", r), d_gnt, tbl[r].e_dgnt);
      chk($sformatf("v%0d_rstrb", r), mem_rstrb, tbl[r].e_rstrb);
      chk($sformatf("v%0d_wmask", r), mem_wmask, tbl[r].e_wmask);
      chk($sformatf("v%0d_maddr", r), mem_addr, tbl[r].e_maddr);
      chk($sformatf("v%0d_i_rvalid", r), i_rvalid, tbl[r].e_irv);
      chk($sformatf("v%0d_d_rvalid", r), d_rvalid, tbl[r].e_drv);
      chk($sformatf("v%0d_i_err", r), i_err, tbl[r].e_ierr);
      chk($sformatf("v%0d_d_err", r), d_err, tbl[r].e_derr);
      chk($sformatf("v%0d_i_rdata", r), i_rdata, tbl[r].e_irdata);
      chk($sformatf("v%0d_d_rdata", r), d_rdata, tbl[r].e_drdata);
    end

    // Both ports requesting continuously: fetch wins every fifth cycle.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h0;
      d_req = 1'b1; d_addr = 32'h4; d_wdata = 32'h0; d_wmask = 4'h0;
      #1;
      $display("starve %0d i_gnt=%0d d_gnt=%0d", k, i_gnt, d_gnt);
      chk($sformatf("st%0d_i_gnt", k), i_gnt, (k % 5) == 4);
      chk($sformatf("st%0d_d_gnt", k), d_gnt, (k % 5) != 4);
      if (k > 0) begin
        chk($sformatf("st%0d_i_rvalid", k), i_rvalid, ((k - 1) % 5) == 4);
        chk($sformatf("st%0d_d_rvalid", k), d_rvalid, ((k - 1) % 5) != 4);
        chk($sformatf("st%0d_rdata", k), i_rdata | d_rdata,
            (((k - 1) % 5) == 4) ? 32'hA5A5_0001 : 32'h5A5A_0002);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("st_tail_i_rvalid", i_rvalid, 1'b1);
    chk("st_tail_i_rdata", i_rdata, 32'hA5A5_0001);

    // Alternating single-port reads: each response one cycle after its own grant.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k < 8) begin
        if (k % 2 == 0) begin i_req = 1'b1; i_addr = 32'h0; end
        else begin d_req = 1'b1; d_addr = 32'h4; end
      end
      #1;
      $display("alt %0d i_gnt=%0d d_gnt=%0d i_rv=%0d d_rv=%0d", k, i_gnt, d_gnt, i_rvalid, d_rvalid);
      chk($sformatf("alt%0d_i_gnt", k), i_gnt, (k < 8) && (k % 2 == 0));
      chk($sformatf("alt%0d_d_gnt", k), d_gnt, (k < 8) && (k % 2 == 1));
      chk($sformatf("alt%0d_i_rvalid", k), i_rvalid, (k > 0) && ((k - 1) % 2 == 0));
      chk($sformatf("alt%0d_d_rvalid", k), d_rvalid, (k > 0) && ((k - 1) % 2 == 1));
      chk($sformatf("alt%0d_i_rdata", k), i_rdata, ((k > 0) && ((k - 1) % 2 == 0)) ? 32'hA5A5_0001 : 32'h0);
      chk($sformatf("alt%0d_d_rdata", k), d_rdata, ((k > 0) && ((k - 1) % 2 == 1)) ? 32'h5A5A_0002 : 32'h0);
    end

    // Reset right after a granted read: its response must never appear.
    @(negedge clk);
    idle_inputs();
    d_req = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE_F00D; d_wmask = 4'hF;
    #1;
    $display("rst_seq write 0x300 d_gnt=%0d", d_gnt);
    chk("rs_wr_gnt", d_gnt, 1'b1);
    @(negedge clk);
    d_wmask = 4'h0;
    #1;
    $display("rst_seq read 0x300 d_gnt=%0d", d_gnt);
    chk("rs_rd_gnt", d_gnt, 1'b1);
    chk("rs_wr_ack", d_rvalid, 1'b1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("rs_in_rvalid", {i_rvalid, d_rvalid}, 2'b00);
      chk("rs_in_err", {i_err, d_err}, 2'b00);
      chk("rs_in_rdata", i_rdata | d_rdata, 32'h0);
      chk("rs_in_gnt", {i_gnt, d_gnt}, 2'b00);
      chk("rs_in_mem", {mem_rstrb, mem_wmask}, 5'b0);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rs_post_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    end
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h300; d_wmask = 4'h0;
    #1;
    chk("rs_reread_gnt", d_gnt, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    $display("rst_seq reread 0x300 d_rdata=%h", d_rdata);
    chk("rs_reread_rvalid", d_rvalid, 1'b1);
    chk("rs_reread_data", d_rdata, 32'hCAFE_F00D);

    // Randomized traffic against the reference model, from a fresh reset.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    denied_run = 0; p_owner = 0; p_err = 1'b0; p_data = 32'h0;
    pend_i = 1'b0; pend_d = 1'b0;
    pi_addr = 32'h0; pd_addr = 32'h0; pd_wdata = 32'h0; pd_mask = 4'h0;
    for (int k = 0; k < 64; k++) shadow[k] = 32'h0;
    for (int n = 0; n < 600; n++) rnd_cycle(n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
